// File: rtl/hyperbus_pkg.sv
// rtl/hyperbus_pkg.sv - shared types for the HyperBus RWDS delay trainer
package hyperbus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SET    = 3'd1,
    SETTLE = 3'd2,
    TEST   = 3'd3,
    EVAL   = 3'd4,
    DONE   = 3'd5
  } trainer_state_e;

  typedef logic [3:0] delay_code_t;
  typedef logic [4:0] win_len_t;

endpackage

// File: rtl/hyperbus_delay_trainer.sv
// rtl/hyperbus_delay_trainer.sv - RWDS delay sweep, widest passing window centred; HYPERBUS_DELAY_TRAINER_PASSMAP_EN adds pass_map_o
module hyperbus_delay_trainer #(
  parameter int          NumTaps       = 16,
  parameter int          SettleCycles  = 8,
  parameter int          SamplesPerTap = 4,
  parameter logic [3:0]  DefaultDelay  = 4'd8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        fail_o,
  output logic [3:0]  delay_o,
  output logic        test_req_o,
  input  logic        test_ack_i,
  input  logic        test_pass_i,
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
  output logic [15:0] pass_map_o,
`endif
  output logic [3:0]  win_start_o,
  output logic [4:0]  win_len_o
);
  import hyperbus_pkg::*;

  trainer_state_e r_state;
  delay_code_t    r_tap, r_delay, r_run_start, r_best_start, r_win_start;
  win_len_t       r_run_len, r_best_len, r_win_len;
  logic [15:0]    r_settle, r_samples;
  logic           r_busy, r_fail, r_req, r_pass;
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
  logic [15:0]    r_pass_map;
`endif

  logic           w_last_tap, w_close;
  delay_code_t    w_cand_start, w_center;
  win_len_t       w_cand_len;

  assign w_last_tap = (r_tap == 4'(NumTaps - 1));
  assign w_close    = !r_pass || w_last_tap;
  // (len-1)>>1 is at most 7, so the 4-bit add wraps exactly like a truncated 5-bit sum
  assign w_center   = r_best_start + 4'((r_best_len - 5'd1) >> 1);

  // Run as it stands after folding in this tap's result
  always_comb begin
    w_cand_start = r_run_start;
    w_cand_len   = r_run_len;
    if (r_pass) begin
      if (r_run_len == 5'd0) w_cand_start = r_tap;
      w_cand_len = r_run_len + 5'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= IDLE;
      r_tap        <= 4'd0;
      r_delay      <= DefaultDelay;
      r_run_start  <= 4'd0;
      r_run_len    <= 5'd0;
      r_best_start <= 4'd0;
      r_best_len   <= 5'd0;
      r_win_start  <= 4'd0;
      r_win_len    <= 5'd0;
      r_settle     <= 16'd0;
      r_samples    <= 16'd0;
      r_busy       <= 1'b0;
      r_fail       <= 1'b0;
      r_req        <= 1'b0;
      r_pass       <= 1'b0;
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
      r_pass_map   <= 16'd0;
`endif
    end else begin
      case (r_state)
        IDLE: if (start_i) begin
          r_state      <= SET;
          r_tap        <= 4'd0;
          r_run_start  <= 4'd0;
          r_run_len    <= 5'd0;
          r_best_start <= 4'd0;
          r_best_len   <= 5'd0;
          r_fail       <= 1'b0;
          r_busy       <= 1'b1;
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
          r_pass_map   <= 16'd0;
`endif
        end
        SET: begin
          r_delay  <= r_tap;
          r_settle <= 16'(SettleCycles);
          r_state  <= SETTLE;
        end
        SETTLE: begin
          r_settle <= r_settle - 16'd1;
          if (r_settle == 16'd1) begin
            r_samples <= 16'd0;
            r_state   <= TEST;
          end
        end
        // Each sample costs one low issue cycle plus the cycles req is held for the ack
        TEST: if (!r_req) begin
          r_req <= 1'b1;
        end else if (test_ack_i) begin
          r_req <= 1'b0;
          if (!test_pass_i) begin
            r_pass  <= 1'b0;
            r_state <= EVAL;
          end else if (r_samples == 16'(SamplesPerTap - 1)) begin
            r_pass  <= 1'b1;
            r_state <= EVAL;
          end else begin
            r_samples <= r_samples + 16'd1;
          end
        end
        EVAL: begin
          if (w_close) begin
            if (w_cand_len > r_best_len) begin
              r_best_start <= w_cand_start;
              r_best_len   <= w_cand_len;
            end
            r_run_len <= 5'd0;
          end else begin
            r_run_start <= w_cand_start;
            r_run_len   <= w_cand_len;
          end
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
          if (r_pass) r_pass_map[r_tap] <= 1'b1;
`endif
          if (w_last_tap) begin
            r_state <= DONE;
          end else begin
            r_tap   <= r_tap + 4'd1;
            r_state <= SET;
          end
        end
        DONE: begin
          if (r_best_len != 5'd0) begin
            r_delay <= w_center;
          end else begin
            r_delay <= DefaultDelay;
            r_fail  <= 1'b1;
          end
          r_win_start <= r_best_start;
          r_win_len   <= r_best_len;
          r_busy      <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy_o      = r_busy;
  assign done_o      = (r_state == DONE);
  assign fail_o      = r_fail;
  assign delay_o     = r_delay;
  assign test_req_o  = r_req;
  assign win_start_o = r_win_start;
  assign win_len_o   = r_win_len;
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
  assign pass_map_o  = r_pass_map;
`endif

endmodule

// File: tb/tb_hyperbus_delay_trainer.sv
// tb/tb_hyperbus_delay_trainer.sv - randomized self-checking bench for hyperbus_delay_trainer
module tb_hyperbus_delay_trainer;

  localparam int NT = 16;
  localparam int SETTLE = 8;
  localparam int SAMP = 4;

  logic clk_i = 1'b0;
  logic rst_i, start_i, test_ack_i, test_pass_i;
  logic busy_o, done_o, fail_o, test_req_o;
  logic [3:0] delay_o, win_start_o;
  logic [4:0] win_len_o;
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
  logic [15:0] pass_map_o;
`endif

  hyperbus_delay_trainer dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .busy_o(busy_o),
    .done_o(done_o), .fail_o(fail_o), .delay_o(delay_o), .test_req_o(test_req_o),
    .test_ack_i(test_ack_i), .test_pass_i(test_pass_i),
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
    .pass_map_o(pass_map_o),
`endif
    .win_start_o(win_start_o), .win_len_o(win_len_o)
  );

  always #5 clk_i = ~clk_i;

  int vectors = 0;
  int miscompares = 0;
  bit tap_pass[NT];
  int fail_sample[NT];
  int req_count[NT];
  int ack_delay;
  logic busy_after_start, fail_after_start;
  int lat, dones;
  bit stopped;
  int e_start, e_len, e_lat, e_delay;
  logic [15:0] e_map;

  function automatic bit tap_ok(int t);
    return tap_pass[t] && (fail_sample[t] == 0);
  endfunction

  function automatic int exp_reqs(int t);
    if (tap_ok(t)) return SAMP;
    if (tap_pass[t]) return fail_sample[t];
    return 1;
  endfunction

  // Window search by scanning every start position; strict > keeps the earliest
  task automatic model();
    e_start = 0; e_len = 0; e_lat = 1; e_map = '0;
    for (int s = 0; s < NT; s++) begin
      int n = 0;
      while (s + n < NT && tap_ok(s + n)) n++;
      if (n > e_len) begin e_len = n; e_start = s; end
      e_lat += 2 + SETTLE + exp_reqs(s) * (ack_delay + 1);
      e_map[s] = tap_ok(s);
    end
    e_delay = (e_len > 0) ? ((e_start + (e_len - 1) / 2) % 16) : 8;
  endtask

  task automatic set_pattern(input logic [15:0] m);
    for (int t = 0; t < NT; t++) begin
      tap_pass[t] = m[t];
      fail_sample[t] = 0;
    end
  endtask

  task automatic run_training(input bit hold, input int stop_tap);
    int high = 0;
    lat = -1; dones = 0; stopped = 0;
    for (int t = 0; t < NT; t++) req_count[t] = 0;
    @(negedge clk_i);
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    busy_after_start = busy_o;
    fail_after_start = fail_o;
    if (!hold) start_i = 1'b0;
    for (int n = 1; n <= 4000; n++) begin
      @(negedge clk_i);
      if (stop_tap >= 0 && int'(delay_o) == stop_tap) begin
        stopped = 1;
        break;
      end
      if (test_req_o) begin
        high++;
        if (high == 1) req_count[delay_o]++;
        if (high == ack_delay) begin
          test_ack_i = 1'b1;
          test_pass_i = tap_pass[delay_o] && (req_count[delay_o] != fail_sample[delay_o]);
        end else begin
          test_ack_i = 1'b0;
        end
      end else begin
        high = 0;
        test_ack_i = 1'b0;
        test_pass_i = 1'b0;
      end
      if (done_o) begin
        dones++;
        if (lat < 0) lat = n;
        start_i = 1'b0;
      end
      if (lat >= 0 && n >= lat + 3) break;
    end
    test_ack_i = 1'b0;
    start_i = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if ({delay_o, busy_o, done_o, fail_o, test_req_o, win_start_o, win_len_o} !== {4'd8, 4'b0, 4'd0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_state: got delay=%0d busy=%b done=%b fail=%b req=%b ws=%0d wl=%0d, want delay=8 rest 0",
               delay_o, busy_o, done_o, fail_o, test_req_o, win_start_o, win_len_o);
    end
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
    vectors++;
    if (pass_map_o !== 16'd0) begin miscompares++; $display("FAIL reset_passmap: got %h want 0000", pass_map_o); end
`endif
  endtask

  task automatic test_window_center();
    set_pattern(16'h07E0); ack_delay = 2; model();
    run_training(0, -1);
    vectors++;
    if ({delay_o, win_start_o, win_len_o, fail_o} !== {4'd7, 4'd5, 5'd6, 1'b0}) begin
      miscompares++;
      $display("FAIL center_5_10: got delay=%0d ws=%0d wl=%0d fail=%b want 7 5 6 0", delay_o, win_start_o, win_len_o, fail_o);
    end
    vectors++;
    if (dones != 1) begin miscompares++; $display("FAIL center_done_pulses: got %0d want 1", dones); end
    vectors++;
    if (lat != e_lat) begin miscompares++; $display("FAIL center_latency: got %0d want %0d", lat, e_lat); end
    vectors++;
    if (busy_after_start !== 1'b1) begin miscompares++; $display("FAIL busy_after_start: got %b want 1", busy_after_start); end
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
    vectors++;
    if (pass_map_o !== e_map) begin miscompares++; $display("FAIL center_passmap: got %h want %h", pass_map_o, e_map); end
`endif
  endtask

  task automatic test_tie();
    set_pattern(16'h0E1C); ack_delay = 1;
    run_training(0, -1);
    vectors++;
    if ({delay_o, win_start_o, win_len_o} !== {4'd3, 4'd2, 5'd3}) begin
      miscompares++;
      $display("FAIL tie_earlier: got delay=%0d ws=%0d wl=%0d want 3 2 3", delay_o, win_start_o, win_len_o);
    end
  endtask

  task automatic test_window_at_end();
    set_pattern(16'hF000); ack_delay = 3;
    run_training(0, -1);
    vectors++;
    if ({delay_o, win_start_o, win_len_o} !== {4'd13, 4'd12, 5'd4}) begin
      miscompares++;
      $display("FAIL end_window: got delay=%0d ws=%0d wl=%0d want 13 12 4", delay_o, win_start_o, win_len_o);
    end
  endtask

  task automatic test_all_fail();
    set_pattern(16'h0000); ack_delay = 2;
    run_training(0, -1);
    vectors++;
    if ({delay_o, fail_o, win_len_o, busy_o} !== {4'd8, 1'b1, 5'd0, 1'b0}) begin
      miscompares++;
      $display("FAIL all_fail: got delay=%0d fail=%b wl=%0d busy=%b want 8 1 0 0", delay_o, fail_o, win_len_o, busy_o);
    end
    set_pattern(16'h00F0);
    run_training(0, -1);
    vectors++;
    if (fail_after_start !== 1'b0) begin miscompares++; $display("FAIL fail_cleared_on_start: got %b want 0", fail_after_start); end
    vectors++;
    if ({delay_o, fail_o} !== {4'd5, 1'b0}) begin
      miscompares++;
      $display("FAIL after_fail_run: got delay=%0d fail=%b want 5 0", delay_o, fail_o);
    end
  endtask

  task automatic test_partial_sample();
    set_pattern(16'h01F0); fail_sample[6] = 3; ack_delay = 2; model();
    run_training(0, -1);
    vectors++;
    if (req_count[6] != 3) begin miscompares++; $display("FAIL tap6_requests: got %0d want 3", req_count[6]); end
    vectors++;
    if ({delay_o, win_start_o, win_len_o} !== {4'd4, 4'd4, 5'd2}) begin
      miscompares++;
      $display("FAIL tap6_window: got delay=%0d ws=%0d wl=%0d want 4 4 2", delay_o, win_start_o, win_len_o);
    end
    vectors++;
    if (lat != e_lat) begin miscompares++; $display("FAIL tap6_latency: got %0d want %0d", lat, e_lat); end
  endtask

  task automatic test_all_pass_latency();
    set_pattern(16'hFFFF); ack_delay = 1;
    run_training(0, -1);
    vectors++;
    if (lat != NT * (2 + SETTLE + SAMP * (ack_delay + 1)) + 1) begin
      miscompares++;
      $display("FAIL all_pass_latency: got %0d want %0d", lat, NT * (2 + SETTLE + SAMP * (ack_delay + 1)) + 1);
    end
    vectors++;
    if ({delay_o, win_start_o, win_len_o} !== {4'd7, 4'd0, 5'd16}) begin
      miscompares++;
      $display("FAIL all_pass_window: got delay=%0d ws=%0d wl=%0d want 7 0 16", delay_o, win_start_o, win_len_o);
    end
  endtask

  task automatic test_back_to_back();
    set_pattern(16'h3C3C); ack_delay = 2; model();
    run_training(1, -1);
    vectors++;
    if (dones != 1 || busy_o !== 1'b0) begin
      miscompares++;
      $display("FAIL held_start: got dones=%0d busy=%b want 1 0", dones, busy_o);
    end
    vectors++;
    if (lat != e_lat || int'(delay_o) != e_delay) begin
      miscompares++;
      $display("FAIL held_start_result: got lat=%0d delay=%0d want %0d %0d", lat, delay_o, e_lat, e_delay);
    end
  endtask

  task automatic test_reset_mid();
    set_pattern(16'hFFFF); ack_delay = 2;
    run_training(0, 9);
    vectors++;
    if (!stopped) begin miscompares++; $display("FAIL reach_tap9: got stopped=0 want 1"); end
    rst_i = 1'b1;
    #1;
    vectors++;
    if ({delay_o, busy_o, test_req_o, win_len_o} !== {4'd8, 1'b0, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_run: got delay=%0d busy=%b req=%b wl=%0d want 8 0 0 0", delay_o, busy_o, test_req_o, win_len_o);
    end
    @(negedge clk_i);
    rst_i = 1'b0;
    @(negedge clk_i);
    vectors++;
    if ({done_o, busy_o, delay_o} !== {1'b0, 1'b0, 4'd8}) begin
      miscompares++;
      $display("FAIL after_reset_idle: got done=%b busy=%b delay=%0d want 0 0 8", done_o, busy_o, delay_o);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 8; it++) begin
      set_pattern(16'($urandom));
      fail_sample[$urandom_range(0, NT - 1)] = $urandom_range(0, SAMP);
      ack_delay = $urandom_range(1, 3);
      model();
      run_training(0, -1);
      vectors++;
      if (int'(delay_o) != e_delay || int'(win_start_o) != e_start || int'(win_len_o) != e_len || fail_o !== (e_len == 0)) begin
        miscompares++;
        $display("FAIL random_%0d_result: got delay=%0d ws=%0d wl=%0d fail=%b want %0d %0d %0d %b",
                 it, delay_o, win_start_o, win_len_o, fail_o, e_delay, e_start, e_len, e_len == 0);
      end
      vectors++;
      if (lat != e_lat || dones != 1) begin
        miscompares++;
        $display("FAIL random_%0d_timing: got lat=%0d dones=%0d want %0d 1", it, lat, dones, e_lat);
      end
`ifdef HYPERBUS_DELAY_TRAINER_PASSMAP_EN
      vectors++;
      if (pass_map_o !== e_map) begin miscompares++; $display("FAIL random_%0d_passmap: got %h want %h", it, pass_map_o, e_map); end
`endif
    end
  endtask

  initial begin
    rst_i = 1'b1; start_i = 1'b0; test_ack_i = 1'b0; test_pass_i = 1'b0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    test_reset();
    rst_i = 1'b0;
    test_window_center();
    test_tie();
    test_window_at_end();
    test_all_fail();
    test_partial_sample();
    test_all_pass_latency();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/hyperbus_delay_trainer.md
Name: hyperbus_delay_trainer

Overview:
Calibration controller that drives the 4-bit RWDS delay-line code of the HyperBus PHY receive path. On request it sweeps all delay taps, waits for each code to settle, and requests read-pattern checks from the PHY. It records which taps pass, finds the longest contiguous passing window, and leaves the delay code at that window's centre. It sits in the PHY control domain, between the configuration registers (start/status) and the delay-line code input.

Parameters:
NumTaps, 16, number of delay codes swept (codes 0..NumTaps-1); must be <= 16
SettleCycles, 8, idle cycles after each code change before testing; >= 1
SamplesPerTap, 4, consecutive passing checks required for a tap to pass; >= 1
DefaultDelay, 4'd8, code driven after reset and after a failed training

Ports:
clk_i  in  1  controller clock
rst_i  in  1  asynchronous, active-high reset
start_i  in  1  training request; sampled only in IDLE
busy_o  out  1  high from start acceptance until DONE exits
done_o  out  1  one-cycle pulse when training ends
fail_o  out  1  sticky: last training found no passing tap; cleared on next accepted start
delay_o  out  4  delay code to the delay line
test_req_o  out  1  pattern-check request to the PHY
test_ack_i  in  1  check complete; test_pass_i is valid in the same cycle
test_pass_i  in  1  check result: 1 = pattern matched
win_start_o  out  4  first tap of the selected window
win_len_o  out  5  length of the selected window, 0..16

Behaviour:
- Reset values: delay_o=DefaultDelay, busy_o=0, done_o=0, fail_o=0, test_req_o=0, win_start_o=0, win_len_o=0; FSM goes to IDLE.
- IDLE: start_i=1 -> SET. Tap counter=0, current-run and best-window registers cleared, fail_o cleared, busy_o=1 from the next cycle.
- SET: delay_o=tap; load settle counter with SettleCycles -> SETTLE.
- SETTLE: decrement the counter each cycle; at 0 -> TEST with sample counter=0.
- TEST: assert test_req_o and hold it until the cycle test_ack_i=1; deassert it in the following cycle. An ack while test_req_o=0 is ignored.
  - pass: increment the sample counter. If the count reaches SamplesPerTap -> EVAL(pass); otherwise request again next cycle.
  - fail: go to EVAL(fail) immediately; the remaining samples are skipped.
- EVAL: one cycle.
  - pass: if run length=0, set run start=tap; then increment run length.
  - fail: close the run. If run length > best length, copy the run into best. Then set run length=0.
  - If tap=NumTaps-1: close any open run -> DONE. Otherwise increment tap -> SET.
- Tie rule: a run replaces the best window only if it is strictly longer, so the earlier window wins.
- DONE: one cycle.
  - Best length>0: delay_o = best_start + ((best_len-1)>>1), using 5-bit arithmetic truncated to 4 bits.
  - Best length=0: delay_o=DefaultDelay and fail_o=1.
  - Update win_start_o and win_len_o; done_o=1 for this cycle only; busy_o=0 from the next cycle -> IDLE.
- start_i while busy is ignored. There is no abort input; only rst_i aborts, and it restores the reset values at once.
- Latency with all checks passing and a fixed ack delay A: NumTaps*(2+SettleCycles+SamplesPerTap*(A+1))+1 cycles from start acceptance to done_o.

Optional Feature:
HYPERBUS_DELAY_TRAINER_PASSMAP_EN
- Defined: adds the output pass_map_o [15:0]. Bit t is set in EVAL when tap t passes. It is cleared on start acceptance and on reset, and holds after DONE.
- Undefined: the port and its register do not exist; all other behaviour is identical.

Decomposition:
- Shared package hyperbus_pkg holds:
  - trainer_state_e, with states IDLE, SET, SETTLE, TEST, EVAL, DONE;
  - the delay code type (logic [3:0]);
  - the window length type (logic [4:0]).
- No sub-module; the window tracker stays inline.

Test Plan:
- Taps 5..10 pass, all others fail; SamplesPerTap=4; ack 2 cycles after request -> delay_o=7, win_start_o=5, win_len_o=6, fail_o=0, exactly one done_o pulse.
- Windows at 2..4 and 9..11 (equal length) -> earlier window kept: delay_o=3, win_start_o=2.
- Taps 12..15 pass, with the run reaching the last tap -> window closed at end: delay_o=13, win_len_o=4.
- Every check fails -> delay_o=8, fail_o=1, win_len_o=0; next start clears fail_o.
- Tap 6 fails on its 3rd sample only -> tap 6 fails and only 3 requests are issued at tap 6.
- rst_i asserted during SETTLE at tap 9 -> delay_o=8, busy_o=0, test_req_o=0 immediately; start_i held high during a run has no effect.
